elastic_pipe_chain: RTL
=======================

// Module: elastic_pipe_chain
// PURPOSE
//   Parametrised chain of STAGES pipeline registers with valid/ready handshake, global stall and per-stage flush.
//   Generalises the fixed IF/ID..MEM/WB registers of the 5-stage CPU, which always write and never flush.
//   One instance carries any payload (control+data bundle) through N stages.
//   Serves as the building block for stall/flush support in the pipelined CPU.
// PARAMETERS
//   WIDTH   32  payload width in bits (>=1)
//   STAGES  4   number of register stages (>=1); stage 0 = input side, stage STAGES-1 drives outputs
//   CNT_W   $clog2(STAGES+2)  localparam, occupancy width
// PORTS
//   clk         in   1             rising-edge clock
//   reset       in   1             synchronous, active-low; chain cleared on an edge where reset==0
//   in_valid    in   1             upstream item present
//   in_ready    out  1             chain accepts in_data this cycle
//   in_data     in   WIDTH         upstream payload
//   out_valid   out  1             item in last stage presented
//   out_ready   in   1             downstream accepts out_data
//   out_data    out  WIDTH         payload of last stage
//   stall       in   1             global hold: no stage moves, no accept, no deliver
//   flush_mask  in   STAGES        bit i: stage i is empty after this edge
//   occupancy   out  CNT_W         number of valid items held (incl. skid entry)
// BEHAVIOUR
//   - Reset (reset==0 at edge): all valid_q=0, all data_q=0, occupancy=0; overrides stall/flush/handshake.
//     After reset: out_valid=0, out_data=0, in_ready=1 (in_ready=0 for one cycle under SKID_EN, see below).
//   - Per stage i: valid_q[i], data_q[i]; rdy[STAGES-1]=out_ready|!valid_q[STAGES-1]; rdy[i]=rdy[i+1]|!valid_q[i].
//   - Stage i loads from stage i-1 (stage 0 from input) when rdy[i]&!stall; otherwise holds; data_q written only on load.
//   - in_ready = rdy[0]&!stall; accept = in_valid&in_ready. out_valid = valid_q[last]&!stall; deliver = out_valid&out_ready.
//   - Full throughput: one item/cycle accepted and delivered simultaneously when chain full and out_ready=1.
//   - Latency: item accepted at edge E is on out_data from edge E+STAGES-1 (STAGES=1: right after E), no backpressure.
//   - Backpressure: out_ready=0 holds last stage; bubbles upstream collapse (chain compacts), in_ready drops only when all stages valid.
//   - stall=1: every register holds, including out_data; in_ready=0, out_valid=0; occupancy unchanged (unless flushed).
//   - flush_mask[i]=1: valid_q[i]=0 after the edge regardless of stall or incoming load; the incoming item is discarded.
//     Item leaving stage i to i+1 at that edge is unaffected. flush_mask[last] with deliver: item is delivered, stage empties.
//     flush_mask[0] with accept: handshake completes, item dropped. data_q of flushed stage keeps its old value.
//   - Flush and stall together: flush wins for masked stages, others hold.
//   - occupancy: registered; next = popcount(next valid_q) (+ skid valid); never exceeds STAGES (+1 with SKID_EN).
// CONFIGURATION
//   ELASTIC_PIPE_SKID_EN defined:
//     - one-entry skid buffer ahead of stage 0; in_ready is a registered flop (no combinational path from out_ready/stall).
//     - in_ready_q = next-cycle space available (skid empty, or skid drains); item arriving while stage 0 blocked goes to skid.
//     - skid empties into stage 0 before new input (FIFO order preserved); when skid empty, input bypasses it, latency unchanged.
//     - flush_mask[0] also clears the skid entry. in_ready=0 in the first cycle after reset, 1 thereafter when empty.
//   Not defined: no skid, in_ready combinational as above, capacity exactly STAGES.
// TESTING
//   T1 STAGES=4, out_ready=1, push 0x11,0x22,0x33 on consecutive edges -> out_data 0x11,0x22,0x33 on edges 3,4,5 after first accept; occupancy peaks 3.
//   T2 out_ready=0, push 6 items -> 4 accepted, in_ready=0, occupancy=4 (5 with SKID_EN); raise out_ready -> all delivered in order, 1/cycle.
//   T3 chain full 0xA0..0xA3, stall=1 for 3 cycles with out_ready=1 -> no deliver, out_valid=0, registers unchanged; stall=0 -> 0xA0 delivered next cycle.
//   T4 chain full, flush_mask=4'b0011 one edge -> two youngest items gone, 0xA0,0xA1 (oldest) delivered, occupancy 4->2 (minus deliveries).
//   T5 reset=0 mid-stream with items in flight and stall=1 -> after edge occupancy=0, out_valid=0, out_data=0; no stale item later emerges.
//   T6 random in_valid/out_ready/stall/flush 10k cycles vs. scoreboard model -> order, no loss except flushed items, no duplicates.

Source files
------------

// File: rtl/elastic_pipe_chain.sv
// Purpose: STAGES-deep valid/ready register chain with global stall and per-stage flush (optional skid via ELASTIC_PIPE_SKID_EN).
// Latency: an item accepted at edge E is on out_data from edge E+STAGES-1; skid bypassed when empty, so latency unchanged.
// Backpressure: out_ready=0 holds the last stage, bubbles collapse upstream, in_ready drops only when every stage is full.
module elastic_pipe_chain #(
    parameter int  WIDTH  = 32,
    parameter int  STAGES = 4,
    localparam int CNT_W  = $clog2(STAGES + 2)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              stall,
    input  logic [STAGES-1:0] flush_mask,
    output logic [CNT_W-1:0]  occupancy
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] load;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0]  src_dat [STAGES];
    logic [STAGES-1:0] valid_n;
    logic [STAGES-1:0] wr_en;
    logic [CNT_W-1:0]  occ_n;

    logic              src0_valid;
    logic [WIDTH-1:0]  src0_data;
    logic              skid_cnt;

    // A stage can take a new item if the output drains or any stage at or after it holds a bubble
    always_comb begin
        rdy = '0;
        for (int i = 0; i < STAGES; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!valid_q[j]) rdy[i] = 1'b1;
            end
        end
    end

    assign load = rdy & {STAGES{!stall}};

    // Each stage's source: the chain head (input or skid) for stage 0, the previous stage otherwise
    for (genvar g = 0; g < STAGES; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_v[g]   = src0_valid;
            assign src_dat[g] = src0_data;
        end else begin : g_link
            assign src_v[g]   = valid_q[g-1];
            assign src_dat[g] = data_q[g-1];
        end
    end

    // Next valid per stage; a flush empties the stage even if an item was arriving
    always_comb begin
        valid_n = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_mask[i])  valid_n[i] = 1'b0;
            else if (load[i])   valid_n[i] = src_v[i];
            else                valid_n[i] = valid_q[i];
        end
    end

    // Payload is only captured for real, surviving items so out_data never shows stale garbage
    assign wr_en = load & src_v & ~flush_mask;

`ifdef ELASTIC_PIPE_SKID_EN
    logic             skid_valid_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             in_ready_q;
    logic             skid_valid_n;
    logic             accept;

    assign in_ready   = in_ready_q;
    assign accept     = in_valid & in_ready_q;
    // Skid holds the older item, so it always feeds stage 0 ahead of fresh input
    assign src0_valid = skid_valid_q | accept;
    assign src0_data  = skid_valid_q ? skid_data_q : in_data;

    // Skid fills when an accepted item cannot enter stage 0, drains when stage 0 loads
    always_comb begin
        skid_valid_n = 1'b0;
        if (flush_mask[0])     skid_valid_n = 1'b0;
        else if (skid_valid_q) skid_valid_n = !load[0];
        else                   skid_valid_n = accept & !load[0];
    end

    assign skid_cnt = skid_valid_n;

    // Skid entry and registered in_ready; in_ready stays low for the first cycle out of reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_n;
            if (accept && !load[0]) skid_data_q <= in_data;
            in_ready_q   <= !skid_valid_n;
        end
    end
`else
    assign in_ready   = load[0];
    assign src0_valid = in_valid;
    assign src0_data  = in_data;
    assign skid_cnt   = 1'b0;
`endif

    // Occupancy tracks the post-edge population of the chain plus the skid entry
    always_comb begin
        occ_n = CNT_W'(skid_cnt);
        for (int i = 0; i < STAGES; i++) begin
            occ_n = occ_n + CNT_W'(valid_n[i]);
        end
    end

    // Stage registers and occupancy; reset overrides stall, flush and handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q   <= '0;
            occupancy <= '0;
            for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
        end else begin
            valid_q   <= valid_n;
            occupancy <= occ_n;
            for (int i = 0; i < STAGES; i++) begin
                if (wr_en[i]) data_q[i] <= src_dat[i];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1] & !stall;
    assign out_data  = data_q[STAGES-1];

endmodule
